// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, the raster phase type and the coordinate type
// used by the timing generator and the renderers downstream of it.
package vga_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the timing generator as consumed by the renderer/compositor chain.
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   line_start;
    logic   frame_start;

    modport master (
        output DrawX,
        output DrawY,
        output blank,
        output hs,
        output vs,
        output line_start,
        output frame_start
    );

    modport slave (
        input DrawX,
        input DrawY,
        input blank,
        input hs,
        input vs,
        input line_start,
        input frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, ACTIVE/FRONT/SYNC/BACK phase tracker and active-low sync.
// Next-state phase and wrap are exported so the top can register blank/pulses in step with the count.
module vga_axis_counter
    import vga_pkg::coord_t;
    import vga_pkg::vga_phase_t;
#(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FP      = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BP      = 48
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       advance,
    output coord_t     count_o,
    output vga_phase_t phase_c,
    output logic       wrap_c,
    output logic       sync_n_o
);

    localparam coord_t FRONT_AT = coord_t'(VISIBLE);
    localparam coord_t SYNC_AT  = coord_t'(VISIBLE + FP);
    localparam coord_t BACK_AT  = coord_t'(VISIBLE + FP + SYNC);
    localparam coord_t LAST     = coord_t'(VISIBLE + FP + SYNC + BP - 1);

    coord_t     cnt_q;
    coord_t     cnt_d;
    vga_phase_t phase_q;
    vga_phase_t phase_d;
    logic       sync_n_q;
    logic       sync_n_d;

    // Phase changes are keyed on the count being entered, so phase_q always matches cnt_q.
    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        wrap_c   = advance && (cnt_q == LAST);
        if (advance) begin
            cnt_d = wrap_c ? '0 : cnt_q + coord_t'(1);
            if (cnt_d == '0) begin
                phase_d = vga_pkg::ACTIVE;
            end else if (cnt_d == FRONT_AT) begin
                phase_d = vga_pkg::FRONT;
            end else if (cnt_d == SYNC_AT) begin
                phase_d = vga_pkg::SYNC;
            end else if (cnt_d == BACK_AT) begin
                phase_d = vga_pkg::BACK;
            end
        end
        sync_n_d = (phase_d != vga_pkg::SYNC);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            cnt_q    <= LAST;
            phase_q  <= vga_pkg::BACK;
            sync_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count_o  = cnt_q;
    assign phase_c  = phase_d;
    assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY, visible-area flag, line/frame pulses and
// hs/vs delayed to line up with the renderers' registered RGB.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    vga_timing_gen_if.master   vga
);

    coord_t     h_count;
    coord_t     v_count;
    vga_phase_t h_phase_c;
    vga_phase_t v_phase_c;
    logic       h_wrap_c;
    logic       v_wrap_c;
    logic       h_sync_n;
    logic       v_sync_n;

    logic       blank_q;
    logic       line_start_q;
    logic       frame_start_q;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .advance  (1'b1),
        .count_o  (h_count),
        .phase_c  (h_phase_c),
        .wrap_c   (h_wrap_c),
        .sync_n_o (h_sync_n)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .advance  (h_wrap_c),
        .count_o  (v_count),
        .phase_c  (v_phase_c),
        .wrap_c   (v_wrap_c),
        .sync_n_o (v_sync_n)
    );

    // Built from next-state values so they land on the same edge as the counters.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            blank_q       <= (h_phase_c == ACTIVE) && (v_phase_c == ACTIVE);
            line_start_q  <= h_wrap_c;
            frame_start_q <= h_wrap_c && v_wrap_c;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hs = h_sync_n;
            assign vga.vs = v_sync_n;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q;
            logic [SYNC_DELAY-1:0] vs_pipe_q;

            // Reset fills every stage with the inactive level so no stale low escapes.
            always_ff @(posedge vga_clk) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= SYNC_DELAY'({hs_pipe_q, h_sync_n});
                    vs_pipe_q <= SYNC_DELAY'({vs_pipe_q, v_sync_n});
                end
            end

            assign vga.hs = hs_pipe_q[SYNC_DELAY-1];
            assign vga.vs = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    assign vga.DrawX       = h_count;
    assign vga.DrawY       = v_count;
    assign vga.blank       = blank_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz raster timing that drives every sprite and background renderer in the display path. Produces the DrawX/DrawY pixel coordinates and the `blank` visible-area flag the renderers consume. Also produces HSYNC/VSYNC, delayed by a programmable pipeline so they stay aligned with the renderers' registered RGB output. Sits between the pixel-clock source and the renderer/compositor chain, one instance per display.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, extra cycles applied to hs/vs to match renderer latency (range 0–4)

Ports:
- `vga_clk` in 1: pixel clock; all logic on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `DrawX` out 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY` out 10: current vertical count, 0..V_TOTAL-1.
- `blank` out 1: 1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); renderers output RGB only when 1.
- `hs` out 1: horizontal sync, active-low, delayed SYNC_DELAY cycles.
- `vs` out 1: vertical sync, active-low, delayed SYNC_DELAY cycles.
- `line_start` out 1: one-cycle pulse when DrawX==0.
- `frame_start` out 1: one-cycle pulse when DrawX==0 and DrawY==0.

## Operation
- Line and frame totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter `hc` increments every cycle and wraps H_TOTAL-1 → 0.
- Vertical counter `vc` increments only on the hc wrap and wraps V_TOTAL-1 → 0 on that same cycle.
- Horizontal phase FSM (H_ACTIVE, H_FRONT, H_SYNC, H_BACK) is derived from hc boundaries:
  - H_ACTIVE→H_FRONT at hc==H_VISIBLE
  - H_FRONT→H_SYNC at H_VISIBLE+H_FP
  - H_SYNC→H_BACK at H_VISIBLE+H_FP+H_SYNC
  - H_BACK→H_ACTIVE at wrap
- Vertical FSM (V_ACTIVE, V_FRONT, V_SYNC, V_BACK) uses the same boundary scheme on vc. It advances only on hc wrap.
- Undelayed hsync is low iff the H FSM is in H_SYNC (hc 656..751). Undelayed vsync is low iff the V FSM is in V_SYNC (vc 490..491).
- `blank` = H_ACTIVE and V_ACTIVE.
- hs/vs pass through a SYNC_DELAY-deep shift register. With SYNC_DELAY=0 they equal the undelayed syncs, registered alongside the counters.
- All outputs are registered. `DrawX`, `DrawY`, `blank`, `line_start` and `frame_start` always describe the same cycle's (hc, vc).
- Reset (reset_n=0 at a posedge):
  - hc=H_TOTAL-1 (799), vc=V_TOTAL-1 (524)
  - both FSMs in their BACK state
  - outputs: DrawX=799, DrawY=524, blank=0, hs=1, vs=1, line_start=0, frame_start=0
  - every sync delay stage is loaded with 1
- The first posedge with reset_n=1 moves to (0,0) with blank=1, line_start=1, frame_start=1.
- Reset asserted mid-frame has the same effect. No partial-frame state survives, and hs/vs show no glitch low.

## Timing
- 1 pixel per vga_clk.
- Line = 800 cycles; frame = 420 000 cycles.
- frame_start period is exactly 420 000 cycles; line_start period is exactly 800 cycles.
- The hs low pulse is 96 cycles wide. Its falling edge occurs SYNC_DELAY cycles after the cycle with DrawX==656.
- vs is low for 1600 cycles. It falls SYNC_DELAY cycles after the cycle with (DrawX,DrawY)==(0,490).
- `blank` is high for exactly 640 consecutive cycles on each of lines 0..479 and is never high on lines 480..524.
- Simultaneous hc and vc wrap at (799,524)→(0,0): both counters wrap on the same edge and frame_start asserts on that edge.

## Structure
- Package `vga_pkg` holds:
  - the 640x480 timing constants and the derived H_TOTAL and V_TOTAL;
  - `typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_phase_t`, shared by both FSMs;
  - a 10-bit `coord_t` typedef, for reuse by renderers.
- Sub-module `vga_axis_counter` (params VISIBLE, FP, SYNC, BP; inputs `advance`, `reset_n`) holds the counter, the phase FSM, the wrap flag and the undelayed sync. It is instantiated twice: horizontal with advance=1, vertical with advance=horizontal wrap.
- The top level holds the blank/pulse logic and the sync delay line.

## Test plan
- Reset, then release at a known edge:
  - during reset: DrawX=799, DrawY=524, blank=0, hs=vs=1
  - first edge after release: DrawX=0, DrawY=0, blank=1, frame_start=1
- Run 2 full frames. Check:
  - blank-high count = 307 200 per frame
  - frame_start spacing = 420 000 cycles
  - line_start spacing = 800 cycles
  - DrawX never exceeds 799 and DrawY never exceeds 524
- SYNC_DELAY=1:
  - hs falls on the cycle after DrawX==656 and rises on the cycle after DrawX==752
  - vs falls on the cycle after (0,490) and rises on the cycle after (0,492)
- SYNC_DELAY=0 and SYNC_DELAY=3: hs falling edge lands exactly 0 and 3 cycles, respectively, after DrawX==656.
- Assert reset_n=0 for 1 cycle at (DrawX,DrawY)=(700,300) with hs low. Required response:
  - hs=1 on that edge
  - the next edge gives (0,0) with frame_start=1
  - hs stays high until the following DrawX==656 plus SYNC_DELAY
